// File: rtl/serial_max_select.sv
// Digit-serial MSB-first unsigned max selector with a fixed, data-independent latency of WIDTH/DIGIT+1 cycles.
// Optional out_min port enabled by defining SERIAL_MAX_SELECT_MIN_OUT_EN.
module serial_max_select #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
    output logic [WIDTH-1:0] out_min,
`endif
    output logic             out_a_gt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_max_select: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        DEC_EQ,
        DEC_AGT,
        DEC_BGT
    } dec_t;

    state_t           state_q, state_d;
    dec_t             dec_q, dec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] hold_a_q, hold_a_d;
    logic [WIDTH-1:0] hold_b_q, hold_b_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             gt_q, gt_d;
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
    logic [WIDTH-1:0] min_q, min_d;
`endif

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    assign dig_a = sh_a_q[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b_q[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dec_q    <= DEC_EQ;
            cnt_q    <= '0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            max_q    <= '0;
            gt_q     <= 1'b0;
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
            min_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            cnt_q    <= cnt_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            max_q    <= max_d;
            gt_q     <= gt_d;
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
            min_q    <= min_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        cnt_d     = cnt_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        max_d     = max_q;
        gt_d      = gt_q;
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
        min_d     = min_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    sh_a_d   = in_a;
                    sh_b_d   = in_b;
                    hold_a_d = in_a;
                    hold_b_d = in_b;
                    dec_d    = DEC_EQ;
                    cnt_d    = '0;
                    state_d  = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (cnt_q == LAST) begin
                    // All digits consumed: register the selection from the settled decision.
                    max_d   = (dec_q == DEC_AGT) ? hold_a_q : hold_b_q;
                    gt_d    = (dec_q == DEC_AGT);
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
                    min_d   = (dec_q == DEC_AGT) ? hold_b_q : hold_a_q;
`endif
                    state_d = ST_DONE;
                end else begin
                    // First differing digit decides; later digits still shift for constant time.
                    if ((dec_q == DEC_EQ) && (dig_a != dig_b)) begin
                        dec_d = (dig_a > dig_b) ? DEC_AGT : DEC_BGT;
                    end
                    sh_a_d = sh_a_q << DIGIT;
                    sh_b_d = sh_b_q << DIGIT;
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_max  = max_q;
    assign out_a_gt = gt_q;
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
    assign out_min  = min_q;
`endif

endmodule

// File: tb/tb_serial_max_select.sv
// Scoreboard bench: DUT 0 (DIGIT=1) gets directed cases plus random pairs, DUT 1 (DIGIT=4) gets 1000 random pairs.
module tb_serial_max_select;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst       [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_a      [2];
    logic [W-1:0] in_b      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [W-1:0] out_max   [2];
    logic         out_a_gt  [2];
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
    logic [W-1:0] out_min   [2];
`endif

    serial_max_select #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_a      (in_a[0]),
        .in_b      (in_b[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_max   (out_max[0]),
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
        .out_min   (out_min[0]),
`endif
        .out_a_gt  (out_a_gt[0])
    );

    serial_max_select #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_a      (in_a[1]),
        .in_b      (in_b[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_max   (out_max[1]),
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
        .out_min   (out_min[1]),
`endif
        .out_a_gt  (out_a_gt[1])
    );

    typedef struct {
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic         gt;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q [2][$];
    exp_t cur   [2];
    bit   prev_v[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input int k, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL dut%0d %s actual=%h expected=%h (cycle %0d)", k, name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input int k, input string name);
        checks++;
        failures++;
        $display("FAIL dut%0d %s (cycle %0d)", k, name, cyc);
    endtask

    // Monitor: pops the expected result when out_valid rises, then watches it while held.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && !prev_v[k]) begin
                if (exp_q[k].size() == 0) begin
                    fail_now(k, "unexpected_output");
                    cur[k].mx = out_max[k];
                    cur[k].gt = out_a_gt[k];
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
                    cur[k].mn = out_min[k];
`endif
                end else begin
                    cur[k] = exp_q[k].pop_front();
                    chk(k, "latency", 32'(cyc - cur[k].acc), 32'(cur[k].lat));
                    chk(k, "out_max", out_max[k], cur[k].mx);
                    chk(k, "out_a_gt", 32'(out_a_gt[k]), 32'(cur[k].gt));
`ifdef SERIAL_MAX_SELECT_MIN_OUT_EN
                    chk(k, "out_min", out_min[k], cur[k].mn);
`endif
                end
            end else if (out_valid[k]) begin
                chk(k, "hold_out_max", out_max[k], cur[k].mx);
                chk(k, "hold_out_a_gt", 32'(out_a_gt[k]), 32'(cur[k].gt));
            end else if (prev_v[k] && !rst[k]) begin
                chk(k, "retain_out_max", out_max[k], cur[k].mx);
            end
            if (out_valid[k]) chk(k, "in_ready_while_valid", 32'(in_ready[k]), 32'd0);
            prev_v[k] = out_valid[k];
        end
    end

    function automatic exp_t model(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.gt  = (a > b);
        e.mx  = (a > b) ? a : b;
        e.mn  = (a > b) ? b : a;
        e.lat = (k == 0) ? (W / 1 + 1) : (W / 4 + 1);
        e.acc = 0;
        return e;
    endfunction

    // Called just after a negedge; returns the cycle number of the accepting edge.
    task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd, output int acc);
        exp_t e;
        int   n;
        n = 0;
        acc = -1;
        in_a[k] = a;
        in_b[k] = b;
        in_valid[k] = 1'b1;
        while (n < 400) begin
            if (in_ready[k]) begin
                e = model(k, a, b);
                e.acc = cyc + 1;
                exp_q[k].push_back(e);
                acc = e.acc;
                break;
            end
            if (rnd) out_ready[k] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        if (acc < 0) fail_now(k, "accept_timeout");
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k, input bit rnd);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || out_valid[k]) && n < 600) begin
            out_ready[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 600) fail_now(k, "drain_timeout");
    endtask

    function automatic void gen(output logic [W-1:0] a, output logic [W-1:0] b);
        a = $urandom;
        case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = a;
            2:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = a ^ ($urandom & 32'h0000_00FF);
        endcase
    endfunction

    task automatic directed_d1();
        int acc;
        int hs;
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;

        out_ready[0] = 1'b1;
        send(0, 32'h0000_0005, 32'h0000_0003, 1'b0, acc);
        drain(0, 1'b0);
        send(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, acc);
        drain(0, 1'b0);
        send(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, acc);
        drain(0, 1'b0);
        send(0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, acc);
        drain(0, 1'b0);
        send(0, 32'h0000_0000, 32'h0000_0000, 1'b0, acc);
        drain(0, 1'b0);
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc);
        drain(0, 1'b0);

        // Back-pressure with a new pair waiting upstream.
        out_ready[0] = 1'b0;
        send(0, 32'h1234_5678, 32'h1234_5679, 1'b0, acc);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[0]) fail_now(0, "bp_valid_timeout");
        in_a[0] = 32'hCAFE_0001;
        in_b[0] = 32'h0000_CAFE;
        in_valid[0] = 1'b1;
        repeat (10) begin
            chk(0, "bp_in_ready", 32'(in_ready[0]), 32'd0);
            chk(0, "bp_out_valid", 32'(out_valid[0]), 32'd1);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        hs = cyc;
        @(negedge clk);
        chk(0, "post_hs_out_valid", 32'(out_valid[0]), 32'd0);
        send(0, 32'hCAFE_0001, 32'h0000_CAFE, 1'b0, acc);
        chk(0, "accept_after_hs", 32'(acc), 32'(hs + 2));
        chk(0, "in_ready_in_scan", 32'(in_ready[0]), 32'd0);
        drain(0, 1'b0);

        // Reset in the middle of a scan discards the pair.
        send(0, 32'h7777_0000, 32'h0000_7777, 1'b0, acc);
        exp_q[0].delete();
        while (cyc < acc + 11) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk(0, "midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk(0, "midrst_out_max", out_max[0], 32'd0);
        chk(0, "midrst_out_a_gt", 32'(out_a_gt[0]), 32'd0);
        chk(0, "midrst_in_ready", 32'(in_ready[0]), 32'd0);
        rst[0] = 1'b0;
        #1;
        chk(0, "postrst_in_ready", 32'(in_ready[0]), 32'd1);
        repeat (40) @(negedge clk);
        chk(0, "no_partial_result", 32'(out_valid[0]), 32'd0);
        send(0, 32'h0000_0010, 32'h0000_0100, 1'b0, acc);
        drain(0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            gen(a, b);
            send(0, a, b, 1'b1, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain(0, 1'b1);
    endtask

    task automatic random_d4();
        int acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            gen(a, b);
            send(1, a, b, 1'b1, acc);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        drain(1, 1'b1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            in_a[k]      = '0;
            in_b[k]      = '0;
            out_ready[k] = 1'b0;
            prev_v[k]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_in_ready", 32'(in_ready[k]), 32'd0);
            chk(k, "rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk(k, "rst_out_max", out_max[k], 32'd0);
            chk(k, "rst_out_a_gt", 32'(out_a_gt[k]), 32'd0);
            rst[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) chk(k, "first_in_ready", 32'(in_ready[k]), 32'd1);
        @(negedge clk);

        fork
            directed_d1();
            random_d4();
        join

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) chk(k, "scoreboard_empty", 32'(exp_q[k].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
